// File: rtl/pipeline_reg_chain.sv
// rtl/pipeline_reg_chain.sv - elastic valid/ready register chain with bubble collapse
// Each stage is a valid bit plus payload; stages advance whenever the next stage is free or draining.
module pipeline_reg_chain #(
   parameter int               WIDTH       = 32,
   parameter int               STAGES      = 2,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             flush,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [WIDTH-1:0]                 in_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [WIDTH-1:0]                 out_data,
   output logic [$clog2(STAGES+1)-1:0]      occupancy
);

   localparam int OW = $clog2(STAGES + 1);

   logic [STAGES-1:0] valid_q, valid_d;
   logic [STAGES-1:0] adv, load;
   logic [WIDTH-1:0]  data_q [STAGES];
   logic [WIDTH-1:0]  data_d [STAGES];
   logic [OW-1:0]     occ_q, occ_d;
   logic              hold, in_xfer, out_xfer;

   always_comb begin
      hold = reset | flush;
      adv  = '0;
      // Resolve advances from the output side back so a draining stage frees its predecessor.
      adv[STAGES-1] = valid_q[STAGES-1] & out_ready & ~hold;
      for (int i = STAGES - 2; i >= 0; i--) begin
         adv[i] = valid_q[i] & (~valid_q[i+1] | adv[i+1]) & ~hold;
      end

      in_ready = (~valid_q[0] | adv[0]) & ~hold;
      in_xfer  = in_valid & in_ready;
      out_xfer = adv[STAGES-1];

      load    = '0;
      load[0] = in_xfer;
      for (int i = 1; i < STAGES; i++) begin
         load[i] = adv[i-1];
      end

      valid_d = flush ? '0 : (load | (valid_q & ~adv));

      data_d[0] = load[0] ? in_data : data_q[0];
      for (int i = 1; i < STAGES; i++) begin
         data_d[i] = load[i] ? data_q[i-1] : data_q[i];
      end

      case ({in_xfer, out_xfer})
         2'b10:   occ_d = occ_q + OW'(1);
         2'b01:   occ_d = occ_q - OW'(1);
         default: occ_d = occ_q;
      endcase
      if (flush) begin
         occ_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         occ_q   <= '0;
         for (int i = 0; i < STAGES; i++) begin
            data_q[i] <= RESET_VALUE;
         end
      end else begin
         valid_q <= valid_d;
         occ_q   <= occ_d;
         for (int i = 0; i < STAGES; i++) begin
            data_q[i] <= data_d[i];
         end
      end
   end

   assign out_valid = valid_q[STAGES-1];
   assign out_data  = data_q[STAGES-1];
   assign occupancy = occ_q;

endmodule

// File: tb/tb_pipeline_reg_chain.sv
// tb/tb_pipeline_reg_chain.sv - scoreboard bench for pipeline_reg_chain at STAGES 2, 3 and 4
module tb_pipeline_reg_chain;

   localparam int N = 3;

   typedef struct {
      logic [7:0] d;
      int         due;
   } sb_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       flush     [N];
   logic       in_valid  [N];
   logic       in_ready  [N];
   logic       out_valid [N];
   logic       out_ready [N];
   logic [7:0] in_data   [N];
   logic [7:0] out_data  [N];
   logic [2:0] occ       [N];

   int  cyc = 0;
   int  checks = 0;
   int  failures = 0;
   sb_t exp_q [N][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < N; g++) begin : g_dut
      logic [$clog2(g+3)-1:0] occ_l;
      pipeline_reg_chain #(.WIDTH(8), .STAGES(g + 2)) u_dut (
         .clk       (clk),
         .reset     (reset),
         .flush     (flush[g]),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_data   (in_data[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_data  (out_data[g]),
         .occupancy (occ_l)
      );
      assign occ[g] = 3'(occ_l);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode 0: no scoreboard entry, 1: order only, 2: order plus STAGES-cycle latency
   task automatic offer(input int k, input logic [7:0] d, input int mode, output logic acc);
      sb_t e;
      in_valid[k] = 1'b1;
      in_data[k]  = d;
      @(negedge clk);
      acc = in_ready[k];
      if (acc && mode > 0) begin
         e.d   = d;
         e.due = (mode == 2) ? cyc + 1 + (k + 2) : -1;
         exp_q[k].push_back(e);
      end
      tick();
   endtask

   task automatic sb_push(input int k, input logic [7:0] d, input int due);
      sb_t e;
      e.d   = d;
      e.due = due;
      exp_q[k].push_back(e);
   endtask

   task automatic drain(input int k, input int budget);
      int n;
      n = 0;
      while (exp_q[k].size() != 0 && n < budget) begin
         tick();
         n++;
      end
      chk("drain_empty", exp_q[k].size(), 0);
   endtask

   initial begin
      logic acc;

      reset = 1'b1;
      for (int k = 0; k < N; k++) begin
         flush[k]     = 1'b0;
         in_valid[k]  = 1'b1;
         in_data[k]   = 8'hEE;
         out_ready[k] = 1'b1;
      end

      fork
         begin : monitor
            sb_t e;
            forever begin
               @(negedge clk);
               for (int k = 0; k < N; k++) begin
                  if (out_valid[k] && out_ready[k] && !flush[k] && !reset) begin
                     if (exp_q[k].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_out k=%0d: got %0h, expected none", k, out_data[k]);
                     end else begin
                        e = exp_q[k].pop_front();
                        chk("out_data", out_data[k], e.d);
                        if (e.due >= 0) chk("out_cycle", cyc + 1, e.due);
                     end
                  end
               end
            end
         end
      join_none

      tick();
      tick();
      for (int k = 0; k < N; k++) begin
         chk("rst_in_ready", in_ready[k], 0);
         chk("rst_out_valid", out_valid[k], 0);
         chk("rst_occ", occ[k], 0);
         chk("rst_out_data", out_data[k], 0);
      end
      reset = 1'b0;
      for (int k = 0; k < N; k++) begin
         in_valid[k]  = 1'b0;
         out_ready[k] = 1'b0;
      end
      tick();
      for (int k = 0; k < N; k++) begin
         chk("idle_in_ready", in_ready[k], 1);
         chk("idle_out_valid", out_valid[k], 0);
      end

      // reset mid-stream, STAGES=2
      offer(0, 8'h0A, 1, acc);
      offer(0, 8'h0B, 1, acc);
      in_valid[0] = 1'b0;
      chk("a_occ_full", occ[0], 2);
      chk("a_head", out_data[0], 8'h0A);
      reset        = 1'b1;
      in_valid[0]  = 1'b1;
      in_data[0]   = 8'h0C;
      out_ready[0] = 1'b1;
      #1;
      chk("a_rst_in_ready", in_ready[0], 0);
      tick();
      reset        = 1'b0;
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b0;
      exp_q[0].delete();
      chk("a_out_valid", out_valid[0], 0);
      chk("a_out_data", out_data[0], 0);
      chk("a_occ", occ[0], 0);
      tick();
      chk("a_no_spurious", out_valid[0], 0);

      // latency and throughput, STAGES=3
      out_ready[1] = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         offer(1, 8'(i), 2, acc);
         chk("b_accept", acc, 1);
      end
      in_valid[1] = 1'b0;
      drain(1, 20);
      chk("b_occ_end", occ[1], 0);

      // backpressure and full pass-through, STAGES=2
      offer(0, 8'h10, 1, acc);
      chk("c_accept0", acc, 1);
      offer(0, 8'h11, 1, acc);
      chk("c_accept1", acc, 1);
      in_data[0] = 8'h12;
      @(negedge clk);
      chk("c_full_in_ready", in_ready[0], 0);
      tick();
      chk("c_occ_full", occ[0], 2);
      chk("c_head_stable0", out_data[0], 8'h10);
      tick();
      chk("c_head_stable1", out_data[0], 8'h10);
      chk("c_head_valid", out_valid[0], 1);
      out_ready[0] = 1'b1;
      offer(0, 8'h12, 1, acc);
      chk("c_passthru_accept", acc, 1);
      chk("c_passthru_occ", occ[0], 2);
      in_valid[0] = 1'b0;
      drain(0, 10);
      chk("c_occ_end", occ[0], 0);

      // flush with three words in flight, STAGES=3
      out_ready[1] = 1'b0;
      offer(1, 8'h21, 1, acc);
      offer(1, 8'h22, 1, acc);
      offer(1, 8'h23, 1, acc);
      in_valid[1] = 1'b0;
      chk("d_occ_full", occ[1], 3);
      flush[1]     = 1'b1;
      in_valid[1]  = 1'b1;
      in_data[1]   = 8'h24;
      out_ready[1] = 1'b1;
      @(negedge clk);
      chk("d_flush_in_ready", in_ready[1], 0);
      tick();
      flush[1]    = 1'b0;
      in_valid[1] = 1'b0;
      exp_q[1].delete();
      chk("d_out_valid", out_valid[1], 0);
      chk("d_occ", occ[1], 0);
      offer(1, 8'h25, 2, acc);
      in_valid[1] = 1'b0;
      drain(1, 10);

      // bubble collapse, STAGES=4
      out_ready[2] = 1'b0;
      offer(2, 8'h31, 0, acc);
      in_valid[2] = 1'b0;
      chk("e_occ1", occ[2], 1);
      tick();
      tick();
      chk("e_not_yet", out_valid[2], 0);
      tick();
      chk("e_arrive", out_valid[2], 1);
      chk("e_arrive_data", out_data[2], 8'h31);
      offer(2, 8'h32, 0, acc);
      in_valid[2] = 1'b0;
      tick();
      tick();
      tick();
      chk("e_occ2", occ[2], 2);
      chk("e_head_stall", out_data[2], 8'h31);
      chk("e_in_ready", in_ready[2], 1);
      out_ready[2] = 1'b1;
      sb_push(2, 8'h31, cyc + 1);
      sb_push(2, 8'h32, cyc + 2);
      drain(2, 10);
      chk("e_occ_end", occ[2], 0);

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
